// File: rtl/frame_reader.sv
// Raster-order frame RAM readout onto a valid/ready byte stream, optionally decimated by STEP.
// 3 cycles per pixel (FETCH, LATCH, SEND); output held stable in SEND until out_ready, abort wins.
module frame_reader #(
    parameter int LINES    = 176,
    parameter int COLUMNS  = 288,
    parameter int S_DATA   = 8,
    parameter int S_LINE   = 8,
    parameter int S_COLUMN = 9,
    parameter int STEP     = 1
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic                start,
    input  logic                abort,
    output logic [S_LINE-1:0]   addr_line,
    output logic [S_COLUMN-1:0] addr_column,
    input  logic [S_DATA-1:0]   q,
    output logic [S_DATA-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sol,
    output logic                out_eof,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, FETCH, LATCH, SEND} state_t;

    state_t              state_q, state_d;
    logic [S_LINE-1:0]   line_q, line_d;
    logic [S_COLUMN-1:0] col_q, col_d;
    logic [S_DATA-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                sol_q, sol_d;
    logic                eof_q, eof_d;
    logic                done_q, done_d;

    // One extra bit so the stride cannot wrap before the bound comparison.
    logic [S_COLUMN:0]   next_col;
    logic [S_LINE:0]     next_line;
    logic                col_wrap;
    logic                line_wrap;
    logic                last;

    assign next_col  = {1'b0, col_q} + (S_COLUMN+1)'(STEP);
    assign next_line = {1'b0, line_q} + (S_LINE+1)'(STEP);
    assign col_wrap  = next_col >= (S_COLUMN+1)'(COLUMNS);
    assign line_wrap = next_line >= (S_LINE+1)'(LINES);
    assign last      = col_wrap && line_wrap;

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        col_d   = col_q;
        data_d  = data_q;
        valid_d = valid_q;
        sol_d   = sol_q;
        eof_d   = eof_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    line_d  = '0;
                    col_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                data_d  = q;
                valid_d = 1'b1;
                sol_d   = (col_q == '0);
                eof_d   = last;
                state_d = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    sol_d   = 1'b0;
                    eof_d   = 1'b0;
                    if (last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        if (col_wrap) begin
                            col_d  = '0;
                            line_d = next_line[S_LINE-1:0];
                        end else begin
                            col_d  = next_col[S_COLUMN-1:0];
                        end
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides everything, including a same-cycle handshake.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            line_d  = line_q;
            col_d   = col_q;
            valid_d = 1'b0;
            sol_d   = 1'b0;
            eof_d   = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            line_q  <= '0;
            col_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sol_q   <= 1'b0;
            eof_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            col_q   <= col_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sol_q   <= sol_d;
            eof_q   <= eof_d;
            done_q  <= done_d;
        end
    end

    assign addr_line   = line_q;
    assign addr_column = col_q;
    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign out_sol     = sol_q;
    assign out_eof     = eof_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: 4x5 frame at STEP=1 and STEP=2, randomized RAM and ready.
module tb_frame_reader;
    localparam int LINES = 4;
    localparam int COLUMNS = 5;

    logic clk, clear_n;
    logic start, abort, rdy, sel;
    logic [7:0] mem [0:3][0:7];

    logic [7:0] al0, al1, ral0, ral1, q0, q1, d0, d1;
    logic [8:0] ac0, ac1, rac0, rac1;
    logic v0, v1, s0, s1, e0, e1, b0, b1, dn0, dn1;

    logic [7:0] o_data, o_al;
    logic [8:0] o_ac;
    logic o_vld, o_sol, o_eof, o_busy, o_done;

    int n_pass, n_chk;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    int done_cnt, done_cyc, first_vld, overlap, unstable;
    bit timed_out, ab_vld, ab_busy;

    frame_reader #(.LINES(LINES), .COLUMNS(COLUMNS), .STEP(1)) u0 (
        .clk(clk), .clear_n(clear_n), .start(start & ~sel), .abort(abort & ~sel),
        .addr_line(al0), .addr_column(ac0), .q(q0), .out_data(d0), .out_valid(v0),
        .out_ready(sel ? 1'b1 : rdy), .out_sol(s0), .out_eof(e0), .busy(b0), .done(dn0));

    frame_reader #(.LINES(LINES), .COLUMNS(COLUMNS), .STEP(2)) u1 (
        .clk(clk), .clear_n(clear_n), .start(start & sel), .abort(abort & sel),
        .addr_line(al1), .addr_column(ac1), .q(q1), .out_data(d1), .out_valid(v1),
        .out_ready(sel ? rdy : 1'b1), .out_sol(s1), .out_eof(e1), .busy(b1), .done(dn1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rd(input logic [7:0] l, input logic [8:0] c);
        if (l < 8'd4 && c < 9'd5) return mem[l[1:0]][c[2:0]];
        return 8'h00;
    endfunction

    // Registered-address RAM, one per reader.
    always @(posedge clk) begin
        ral0 <= al0; rac0 <= ac0;
        ral1 <= al1; rac1 <= ac1;
    end
    assign q0 = rd(ral0, rac0);
    assign q1 = rd(ral1, rac1);

    assign o_data = sel ? d1 : d0;
    assign o_vld  = sel ? v1 : v0;
    assign o_sol  = sel ? s1 : s0;
    assign o_eof  = sel ? e1 : e0;
    assign o_busy = sel ? b1 : b0;
    assign o_done = sel ? dn1 : dn0;
    assign o_al   = sel ? al1 : al0;
    assign o_ac   = sel ? ac1 : ac0;

    function automatic void fill_pattern();
        for (int l = 0; l < 4; l++)
            for (int c = 0; c < 8; c++) mem[l][c] = 8'(l * 16 + c);
    endfunction

    function automatic void fill_random();
        for (int l = 0; l < 4; l++)
            for (int c = 0; c < 8; c++) mem[l][c] = 8'($urandom_range(255));
    endfunction

    // Reference: visit every STEP-th line and column, sol at column 0, eof on the final byte.
    function automatic void build_exp(input int step);
        logic [9:0] e;
        exp_q.delete();
        for (int l = 0; l < LINES; l += step)
            for (int c = 0; c < COLUMNS; c += step)
                exp_q.push_back({(c == 0), 1'b0, mem[l][c]});
        e = exp_q[exp_q.size()-1];
        e[8] = 1'b1;
        exp_q[exp_q.size()-1] = e;
    endfunction

    // Starts a frame and records the accepted stream plus protocol observations.
    task automatic collect(input int max_cyc, input int rdy_pct, input int stall_idx,
                           input int stall_len, input int abort_idx, input int start_idx);
        int cyc, stall_rem, tail;
        bit prev_vld, prev_hs, aborted, ab_pend, start_sent, hs;
        logic [7:0] pd, pal;
        logic [8:0] pac;
        logic ps, pe;
        got_q.delete();
        done_cnt = 0; done_cyc = -1; first_vld = -1; overlap = 0; unstable = 0;
        timed_out = 0; ab_vld = 0; ab_busy = 0;
        cyc = 0; stall_rem = stall_len; tail = -1;
        prev_vld = 0; prev_hs = 0; aborted = 0; ab_pend = 0; start_sent = 0;
        pd = '0; pal = '0; pac = '0; ps = 0; pe = 0;
        @(negedge clk); start = 1; abort = 0; rdy = 0;
        @(negedge clk); start = 0;
        forever begin
            if (prev_vld && !prev_hs && !aborted) begin
                if (!o_vld || o_data !== pd || o_sol !== ps || o_eof !== pe ||
                    o_al !== pal || o_ac !== pac) unstable++;
            end
            if (o_vld && first_vld < 0) first_vld = cyc;
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                if (o_vld) overlap++;
                if (tail < 0) tail = 3;
            end
            if (ab_pend) begin
                ab_vld = o_vld; ab_busy = o_busy; ab_pend = 0; tail = 3;
            end
            if (tail == 0) break;
            if (tail > 0) tail--;
            if (cyc >= max_cyc) begin timed_out = 1; break; end
            start = 0; abort = 0;
            if (o_vld && got_q.size() == stall_idx && stall_rem > 0) begin
                rdy = 0; stall_rem--;
            end else rdy = ($urandom_range(99) < rdy_pct);
            if (o_vld && !aborted && got_q.size() == abort_idx) begin
                abort = 1; aborted = 1; ab_pend = 1;
            end
            if (o_vld && !start_sent && got_q.size() == start_idx) begin
                start = 1; start_sent = 1;
            end
            hs = o_vld && rdy && !abort;
            if (hs) got_q.push_back({o_sol, o_eof, o_data});
            prev_vld = o_vld; prev_hs = hs;
            pd = o_data; ps = o_sol; pe = o_eof; pal = o_al; pac = o_ac;
            @(negedge clk); cyc++;
        end
        start = 0; abort = 0; rdy = 0;
    endtask

    task automatic test_reset();
        int n;
        sel = 0; start = 0; abort = 0; rdy = 0; clear_n = 0;
        fill_pattern();
        #1;
        n_chk++; if ({o_vld, o_busy, o_done} !== 3'b000) $display("FAIL reset_init_flags: got %b exp 000", {o_vld, o_busy, o_done}); else n_pass++;
        n_chk++; if ({o_al, o_ac} !== 17'd0) $display("FAIL reset_init_addr: got %h exp 0", {o_al, o_ac}); else n_pass++;
        @(negedge clk); clear_n = 1;
        @(negedge clk); start = 1; rdy = 1;
        @(negedge clk); start = 0;
        n = 0;
        while (!(o_vld && o_ac == 9'd3) && n < 100) begin @(negedge clk); n++; end
        rdy = 0;
        n_chk++; if (n >= 100) $display("FAIL reset_reach_byte3: got timeout exp byte 3 valid"); else n_pass++;
        @(negedge clk); @(negedge clk);
        n_chk++; if ({o_vld, o_busy, o_data} !== {2'b11, 8'h03}) $display("FAIL reset_pre_stall: got %b%b %h exp 11 03", o_vld, o_busy, o_data); else n_pass++;
        #2 clear_n = 0;
        #1;
        n_chk++; if ({o_vld, o_busy, o_done, o_sol, o_eof} !== 5'b0) $display("FAIL reset_async_flags: got %b exp 00000", {o_vld, o_busy, o_done, o_sol, o_eof}); else n_pass++;
        n_chk++; if ({o_al, o_ac, o_data} !== 25'd0) $display("FAIL reset_async_addr_data: got %h exp 0", {o_al, o_ac, o_data}); else n_pass++;
        @(negedge clk);
        clear_n = 1;
        @(negedge clk);
        n_chk++; if ({o_busy, o_done} !== 2'b00) $display("FAIL reset_no_done: got %b exp 00", {o_busy, o_done}); else n_pass++;
    endtask

    task automatic test_full_frame();
        sel = 0; fill_pattern(); build_exp(1);
        collect(400, 100, -1, 0, -1, -1);
        n_chk++; if (got_q.size() != exp_q.size()) $display("FAIL full_count: got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_chk++; if (got_q[i] !== exp_q[i]) $display("FAIL full_byte%0d: got %h exp %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_chk++; if (first_vld != 2) $display("FAIL full_latency: got %0d exp 2", first_vld); else n_pass++;
        n_chk++; if (done_cnt != 1) $display("FAIL full_done_cnt: got %0d exp 1", done_cnt); else n_pass++;
        n_chk++; if (done_cyc != 60) $display("FAIL full_done_cyc: got %0d exp 60", done_cyc); else n_pass++;
        n_chk++; if (overlap != 0 || timed_out) $display("FAIL full_protocol: got overlap %0d timeout %0d exp 0 0", overlap, timed_out); else n_pass++;
    endtask

    task automatic test_backpressure();
        sel = 0; fill_pattern(); build_exp(1);
        collect(400, 100, 3, 7, -1, -1);
        n_chk++; if (got_q.size() != exp_q.size()) $display("FAIL bp_count: got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_chk++; if (got_q[i] !== exp_q[i]) $display("FAIL bp_byte%0d: got %h exp %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_chk++; if (unstable != 0) $display("FAIL bp_stable: got %0d changes exp 0", unstable); else n_pass++;
        n_chk++; if (done_cyc != 67 || done_cnt != 1) $display("FAIL bp_done: got cyc %0d cnt %0d exp 67 1", done_cyc, done_cnt); else n_pass++;
    endtask

    task automatic test_decimation();
        logic [7:0] lit [0:5];
        lit[0] = 8'h00; lit[1] = 8'h02; lit[2] = 8'h04;
        lit[3] = 8'h20; lit[4] = 8'h22; lit[5] = 8'h24;
        sel = 1; fill_pattern(); build_exp(2);
        collect(400, 100, -1, 0, -1, -1);
        n_chk++; if (got_q.size() != 6) $display("FAIL dec_count: got %0d exp 6", got_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < 6; i++) begin
            n_chk++; if (got_q[i] !== exp_q[i] || got_q[i][7:0] !== lit[i]) $display("FAIL dec_byte%0d: got %h exp %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_chk++; if (done_cyc != 18 || done_cnt != 1) $display("FAIL dec_done: got cyc %0d cnt %0d exp 18 1", done_cyc, done_cnt); else n_pass++;
    endtask

    task automatic test_abort();
        sel = 0; fill_random(); build_exp(1);
        collect(400, 70, -1, 0, 7, -1);
        n_chk++; if (got_q.size() != 7) $display("FAIL abort_count: got %0d exp 7", got_q.size()); else n_pass++;
        n_chk++; if ({ab_vld, ab_busy} !== 2'b00) $display("FAIL abort_idle: got vld %0d busy %0d exp 0 0", ab_vld, ab_busy); else n_pass++;
        n_chk++; if (done_cnt != 0) $display("FAIL abort_no_done: got %0d exp 0", done_cnt); else n_pass++;
        collect(800, 60, -1, 0, -1, -1);
        n_chk++; if (got_q.size() != exp_q.size()) $display("FAIL abort_restart_count: got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        n_chk++; if (got_q.size() == 0 || got_q[0] !== exp_q[0]) $display("FAIL abort_restart_first: got %h exp %h", (got_q.size() ? got_q[0] : 10'h3ff), exp_q[0]); else n_pass++;
        n_chk++; if (got_q != exp_q) $display("FAIL abort_restart_seq: got %0d bytes exp %0d, contents differ", got_q.size(), exp_q.size()); else n_pass++;
    endtask

    task automatic test_start_busy();
        sel = 0; fill_pattern(); build_exp(1);
        collect(400, 100, -1, 0, -1, 2);
        n_chk++; if (got_q != exp_q) $display("FAIL startbusy_seq: got %0d bytes exp %0d, contents differ", got_q.size(), exp_q.size()); else n_pass++;
        n_chk++; if (done_cnt != 1 || done_cyc != 60) $display("FAIL startbusy_done: got cnt %0d cyc %0d exp 1 60", done_cnt, done_cyc); else n_pass++;
    endtask

    task automatic test_start_abort_idle();
        sel = 0;
        @(negedge clk); start = 1; abort = 1;
        @(negedge clk); start = 0; abort = 0;
        n_chk++; if (o_busy !== 1'b0) $display("FAIL start_abort_idle: got busy %b exp 0", o_busy); else n_pass++;
        @(negedge clk);
        n_chk++; if ({o_busy, o_vld} !== 2'b00) $display("FAIL start_abort_idle_hold: got %b exp 00", {o_busy, o_vld}); else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            sel = it[0];
            fill_random(); build_exp(sel ? 2 : 1);
            collect(1500, 30 + $urandom_range(60), -1, 0, -1, -1);
            n_chk++; if (got_q != exp_q) $display("FAIL rand%0d_seq: got %0d bytes exp %0d, contents differ", it, got_q.size(), exp_q.size()); else n_pass++;
            n_chk++; if (done_cnt != 1 || overlap != 0 || unstable != 0 || timed_out) $display("FAIL rand%0d_protocol: got done %0d overlap %0d unstable %0d timeout %0d exp 1 0 0 0", it, done_cnt, overlap, unstable, timed_out); else n_pass++;
        end
    endtask

    initial begin
        n_pass = 0; n_chk = 0;
        sel = 0; start = 0; abort = 0; rdy = 0; clear_n = 0;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_decimation();
        test_abort();
        test_start_busy();
        test_start_abort_idle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/frame_reader.md
Name: frame_reader

Overview:
- Reads back a captured frame from the frame RAM (registered-address, 1-cycle read latency) in raster order.
- Streams the pixel bytes out over a valid/ready interface toward the serial transmitter or colour classifier.
- Optional decimation: samples every STEP-th line and every STEP-th column to reduce link bandwidth.
- Sits between the frame RAM read port and the downstream consumer. While `busy` is high, top level muxes `addr_line`/`addr_column` from this block and holds RAM `we` low.

Parameters:
- LINES, 176, frame height in lines
- COLUMNS, 288, frame width in columns
- S_DATA, 8, pixel byte width
- S_LINE, 8, line address width
- S_COLUMN, 9, column address width
- STEP, 1, decimation stride for both lines and columns (>=1)

Ports:
- clk  in  1  system clock, rising edge
- clear_n  in  1  asynchronous active-low reset
- start  in  1  begin a frame readout; sampled only in IDLE
- abort  in  1  cancel readout; return to IDLE
- addr_line  out  S_LINE  RAM line address
- addr_column  out  S_COLUMN  RAM column address
- q  in  S_DATA  RAM read data; valid one cycle after the address is presented
- out_data  out  S_DATA  pixel byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts the byte
- out_sol  out  1  start of line (column 0); qualified by out_valid
- out_eof  out  1  last pixel of frame; qualified by out_valid
- busy  out  1  readout in progress (state != IDLE)
- done  out  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Reset (clear_n=0, asynchronous): state IDLE; line and column counters 0; all outputs 0. Reset mid-readout discards the frame and produces no done.
- FSM states: IDLE, FETCH, LATCH, SEND.
  - IDLE: start=1 clears counters (line=0, col=0) and moves to FETCH. done=0 except during its pulse.
  - FETCH: addr_line/addr_column drive the counters; the RAM registers them on this edge. Next state LATCH.
  - LATCH: out_data <= q. out_valid <= 1. out_sol <= (col==0). out_eof <= last. Next state SEND.
  - SEND: out_valid=1. out_data, out_sol and out_eof stay stable until out_ready=1.
    - On handshake with not last: advance counters, clear out_valid, go to FETCH.
    - On handshake with last: clear out_valid, pulse done for one cycle, go to IDLE.
- Address outputs are held constant from FETCH through SEND. They change only on counter advance.
- Throughput: one pixel per 3 cycles with out_ready tied high. Latency from start to first out_valid is 3 edges (IDLE->FETCH, FETCH->LATCH, LATCH->SEND sets valid).
- Counter advance:
  - next_col = col + STEP, computed at S_COLUMN+1 bits. If next_col >= COLUMNS: col=0 and line advances by STEP (computed at S_LINE+1 bits). Otherwise col=next_col.
  - last = (col+STEP >= COLUMNS) and (line+STEP >= LINES).
  - Total bytes per frame = ceil(LINES/STEP) * ceil(COLUMNS/STEP).
- abort=1 in any non-IDLE state: next edge goes to IDLE, clears out_valid/out_sol/out_eof, and produces no done. abort has priority over the handshake in the same cycle.
- start while busy is ignored. start and abort together in IDLE: abort wins; stay in IDLE.
- out_valid never drops without a handshake, except on abort or reset.
- done and out_valid are never high in the same cycle.

Test Plan:
- Reset: assert clear_n=0 mid-SEND with out_ready=0. Required: out_valid, busy, done, addresses all 0 immediately, with no clock edge needed.
- Full frame: LINES=4, COLUMNS=5, STEP=1, RAM preloaded with q=line*16+col, out_ready=1.
  - Required: 20 bytes 0x00..0x04, 0x10..0x14, ..., 0x30..0x34 in order.
  - out_sol on bytes 0, 5, 10, 15; out_eof on byte 19.
  - done pulses once, 1 cycle after the last handshake; 60 cycles total.
- Backpressure: same frame; hold out_ready=0 for 7 cycles on byte 3. Required: out_data=0x03 stable with out_valid=1 throughout, addresses stable, no bytes skipped or duplicated.
- Decimation: LINES=4, COLUMNS=5, STEP=2. Required: 6 bytes 0x00, 0x02, 0x04, 0x20, 0x22, 0x24; out_eof on 0x24.
- Abort: assert abort during byte 7's SEND. Required: IDLE next edge, out_valid=0, no done. A following start restarts at 0x00.
- Start while busy: pulse start during byte 2. Required: ignored, sequence continues to 0x34 and a single done.
